// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   muldiv_op_e    : funct3 encodings of the M-extension operations
//   muldiv_state_e : control FSM states
//   DIV0_QUOTIENT  : quotient returned for division by zero
//   INT_MIN        : most negative 32-bit value (signed overflow case)
//   is_signed_a/b  : operand signedness for a given operation
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  function automatic logic is_signed_a(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fixup.sv
// Combinational sign correction and result selection.
//   op      : operation being completed
//   raw     : multiply -> 64-bit magnitude product {hi,lo};
//             divide   -> {remainder magnitude, quotient magnitude}
//   neg     : negate product / quotient
//   neg_rem : negate remainder
//   result  : final 32-bit architectural result
module muldiv_sign_fixup
  import muldiv_pkg::*;
(
  input  muldiv_op_e  op,
  input  logic [63:0] raw,
  input  logic        neg,
  input  logic        neg_rem,
  output logic [31:0] result
);

  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    prod = neg ? (~raw + 64'd1) : raw;
    quot = neg ? (~raw[31:0] + 32'd1) : raw[31:0];
    rem  = neg_rem ? (~raw[63:32] + 32'd1) : raw[63:32];
    case (op)
      OP_MUL:                       result = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[63:32];
      OP_DIV, OP_DIVU:              result = quot;
      default:                      result = rem;
    endcase
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Radix-2: one multiplier bit (shift-add) or one quotient bit (restoring
// shift-subtract) per cycle, 32 cycles per op; division by zero and signed
// overflow complete in one cycle.
//   clk, rst       : clock, synchronous active-high reset
//   start, flush   : instruction valid / kill (flush dominates)
//   op, a, b, rd_in: funct3, operands and destination register
//   busy           : iterating (RUN)
//   stall          : hold front of pipeline
//   done           : one-cycle pulse, result/rd_out valid
//   result, rd_out : registered result and its destination register
module execute_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CNT_W = $clog2(ITER);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_op_e       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic [31:0]      m_q, m_d;    // multiplicand (mul) or divisor (div)
  logic [31:0]      hi_q, hi_d;  // product high half / partial remainder
  logic [31:0]      lo_q, lo_d;  // multiplier->product low / dividend->quotient
  logic [31:0]      result_q, result_d;
  logic [4:0]       rd_out_q, rd_out_d;

  // Accept-side decode
  muldiv_op_e  op_in;
  logic        sa, sb, accept, fast;
  logic [31:0] a_mag, b_mag, fast_result;

  always_comb begin
    op_in  = muldiv_op_e'(op);
    sa     = is_signed_a(op_in) & a[31];
    sb     = is_signed_b(op_in) & b[31];
    a_mag  = sa ? (~a + 32'd1) : a;
    b_mag  = sb ? (~b + 32'd1) : b;
    accept = start & ~flush & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    fast   = op[2] & ((b == 32'd0) |
             (((op_in == OP_DIV) | (op_in == OP_REM)) & (a == INT_MIN) & (b == 32'hFFFF_FFFF)));
    // op[1] separates REM/REMU from DIV/DIVU
    if (b == 32'd0) fast_result = op[1] ? a : DIV0_QUOTIENT;
    else            fast_result = op[1] ? 32'd0 : INT_MIN;
  end

  // One iteration of each datapath
  logic [32:0] mul_sum, rem_sh;
  logic        ge;
  logic [31:0] step_hi, step_lo, fix_result;

  always_comb begin
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : 32'd0)};
    rem_sh  = {hi_q, lo_q[31]};
    ge      = rem_sh >= {1'b0, m_q};
    if (op_q[2]) begin
      // Remainder after restore is below the divisor, so 32 bits hold it
      step_hi = ge ? 32'(rem_sh - {1'b0, m_q}) : rem_sh[31:0];
      step_lo = {lo_q[30:0], ge};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], lo_q[31:1]};
    end
  end

  // Fix-up sees the post-iteration value so the last step and the sign
  // correction land on the same RUN->DONE edge.
  muldiv_sign_fixup u_fixup (
    .op      (op_q),
    .raw     ({step_hi, step_lo}),
    .neg     (neg_q),
    .neg_rem (neg_rem_q),
    .result  (fix_result)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          op_d      = op_in;
          rd_d      = rd_in;
          neg_d     = sa ^ sb;
          neg_rem_d = sa;
          m_d       = op[2] ? b_mag : a_mag;
          lo_d      = op[2] ? a_mag : b_mag;
          hi_d      = 32'd0;
          if (fast) begin
            state_d  = ST_DONE;
            result_d = fast_result;
            rd_out_d = rd_in;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CNT_W'(ITER - 1);
          end
        end
      end
      ST_RUN: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          result_d = fix_result;
          rd_out_d = rd_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign stall  = busy | (accept & ~fast);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: table of directed vectors plus
// hand-written flush / reset / back-to-back sequences.
module tb_execute_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd_in;
  logic        busy, stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        fast;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op, then follow it to done with a bounded wait.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input logic fast, input logic [31:0] exp,
                        input string tag);
    int   lat;
    logic run_ok;
    lat    = 0;
    run_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y; rd_in = r;
    @(negedge clk);
    check({tag, " stall_c0"}, 32'(stall), fast ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    // Inputs scrambled after accept must not matter
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; rd_in = 5'd31;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      if (!stall || !busy) run_ok = 1'b0;
      @(posedge clk); #1;
    end
    check({tag, " latency"}, 32'(lat), fast ? 32'd1 : 32'd33);
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, 32'(rd_out), 32'(r));
    check({tag, " stall_done"}, 32'(stall), 32'd0);
    check({tag, " run_stall"}, 32'(run_ok), 32'd1);
    $display("op=%0d a=%08h b=%08h rd=%0d -> result=%08h rd_out=%0d latency=%0d",
             o, x, y, r, result, rd_out, lat);
  endtask

  task automatic no_done(input int n, input string tag);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check(tag, 32'(cnt), 32'd0);
  endtask

  int d1, d2;

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1,  1'b0, 32'hFFFF_FFEB}; // MUL
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  1'b0, 32'hFFFF_FFFE}; // MULHU
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  1'b0, 32'h0000_0000}; // MULH
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,         5'd4,  1'b0, 32'hFFFF_FFFF}; // MULHSU
    vecs[4]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd5,  1'b0, 32'h4000_0000}; // MULH
    vecs[5]  = '{3'b100, 32'hFFFF_FFEC,  32'd3,         5'd6,  1'b0, 32'hFFFF_FFFA}; // DIV
    vecs[6]  = '{3'b110, 32'hFFFF_FFEC,  32'd3,         5'd7,  1'b0, 32'hFFFF_FFFE}; // REM
    vecs[7]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd8,  1'b0, 32'hFFFF_FFFD}; // DIV
    vecs[8]  = '{3'b110, 32'd7,          32'hFFFF_FFFE, 5'd9,  1'b0, 32'd1};         // REM
    vecs[9]  = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 1'b0, 32'd0};         // DIVU
    vecs[10] = '{3'b100, 32'h8000_0000,  32'd1,         5'd11, 1'b0, 32'h8000_0000}; // DIV
    vecs[11] = '{3'b100, 32'd5,          32'd0,         5'd12, 1'b1, 32'hFFFF_FFFF}; // DIV /0
    vecs[12] = '{3'b111, 32'd5,          32'd0,         5'd13, 1'b1, 32'd5};         // REMU /0
    vecs[13] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 1'b1, 32'h8000_0000}; // DIV ovf
    vecs[14] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 1'b1, 32'd0};         // REM ovf
    vecs[15] = '{3'b111, 32'd100,        32'd7,         5'd16, 1'b0, 32'd2};         // REMU
    vecs[16] = '{3'b101, 32'd100,        32'd7,         5'd17, 1'b0, 32'd14};        // DIVU

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", 32'(rd_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].fast, vecs[i].exp,
             $sformatf("vec%0d", i));

    // Flush in cycle 10 of a DIV
    @(posedge clk); #1;
    start = 1'b1; op = 3'b100; a = 32'd1000; b = 32'd3; rd_in = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush busy_c10", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush busy_c11", 32'(busy), 32'd0);
    check("flush done_c11", 32'(done), 32'd0);
    check("flush result_kept", result, vecs[NV-1].exp);
    check("flush rd_kept", 32'(rd_out), 32'(vecs[NV-1].rd));
    no_done(40, "flush no_done");
    $display("flush mid-DIV -> result=%08h rd_out=%0d", result, rd_out);

    // start and flush together: not accepted
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'b101; a = 32'd50; b = 32'd5; rd_in = 5'd21;
    @(negedge clk);
    check("startflush stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("startflush busy", 32'(busy), 32'd0);
    no_done(40, "startflush no_done");
    check("startflush result", result, vecs[NV-1].exp);
    $display("start+flush -> result=%08h busy=%0d", result, busy);

    // Reset in cycle 20 of a MUL
    @(posedge clk); #1;
    start = 1'b1; op = 3'b000; a = 32'd7; b = 32'd9; rd_in = 5'd22;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid done", 32'(done), 32'd0);
    check("rst_mid stall", 32'(stall), 32'd0);
    check("rst_mid result", result, 32'd0);
    check("rst_mid rd_out", 32'(rd_out), 32'd0);
    no_done(40, "rst_mid no_done");
    $display("reset mid-MUL -> result=%08h rd_out=%0d", result, rd_out);

    // Back-to-back: DIVU 100/7 then MUL 3*4 accepted in the DONE cycle
    d1 = 0; d2 = 0;
    @(posedge clk); #1;
    start = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7; rd_in = 5'd3;
    for (int c = 1; c <= 72; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        op = 3'b000; a = 32'd3; b = 32'd4; rd_in = 5'd4;
      end
      start = (c <= 32) ? ((c % 3) != 0) : (c == 33);
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (c == 33) begin
        check("b2b result1", result, 32'd14);
        check("b2b rd1", 32'(rd_out), 32'd3);
        check("b2b stall_c33", 32'(stall), 32'd1);
      end
      if (c == 66) begin
        check("b2b result2", result, 32'd12);
        check("b2b rd2", 32'(rd_out), 32'd4);
      end
    end
    check("b2b done1_cycle", 32'(d1), 32'd33);
    check("b2b done2_cycle", 32'(d2), 32'd66);
    $display("back-to-back -> done cycles %0d and %0d, result=%08h", d1, d2, result);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the Execute stage. It consumes forwarded operands and the destination register from the decode-to-execute pipeline register.
- Produces a 32-bit result plus the destination register for the execute-to-memory register.
- While an operation is in flight, asserts a stall so the front of the pipeline holds.
- Radix-2 shift-add/shift-subtract datapath: 32 iterations per operation, with a one-cycle fast path for special division cases.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- ITER, 32, iterations per non-fast-path operation (equals XLEN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  valid M-extension instruction present in Execute this cycle
- flush  in  1  kill any in-flight or starting operation (branch/jump redirect)
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  32  rs1 operand (post-forwarding)
- b  in  32  rs2 operand (post-forwarding)
- rd_in  in  5  destination register of the instruction
- busy  out  1  operation in progress (RUN state)
- stall  out  1  combinational: busy OR (start AND accepted-this-cycle AND NOT fast-path)
- done  out  1  one-cycle pulse: result/rd_out valid
- result  out  32  operation result, held until next accepted start
- rd_out  out  5  destination register latched at accept, held with result

Behaviour:
- Reset values (sync, rst high at posedge): state IDLE, busy 0, done 0, result 0, rd_out 0, counter 0, internal accumulators 0. rst mid-operation aborts silently; no done pulse.
- FSM states:
  - IDLE: start accepted.
  - RUN: iterating; start ignored.
  - DONE: done=1 for exactly one cycle; start accepted, next state RUN, or DONE via fast path.
  - Without start, DONE returns to IDLE.
- Accept, when start=1 and flush=0 in IDLE/DONE:
  - Latch op and rd_in.
  - Latch magnitudes |a| and |b| per op signedness. MULH/DIV/REM: both signed. MULHSU: a signed, b unsigned. Others: unsigned.
  - Latch sign flags: product/quotient negate = sa XOR sb; remainder negate = sa.
- Fast path, taken on accept and going directly to DONE (done in cycle 1, stall 0 in cycle 0):
  - b==0:
    - DIV/DIVU: result 0xFFFFFFFF.
    - REM/REMU: result = a.
  - DIV with a==0x80000000 and b==0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
- Normal latency:
  - Accept in cycle 0.
  - RUN in cycles 1..32, with the counter going 31 down to 0.
  - DONE with done=1 in cycle 33.
  - stall is high in cycles 0..32 and low in cycle 33, so the pipeline advances while done is high.
- Multiply:
  - 64-bit unsigned shift-add of magnitudes, one multiplier bit per cycle.
  - Negate the 64-bit product if the flag is set.
  - MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits.
- Divide:
  - Restoring division, one quotient bit per cycle, 33-bit partial remainder.
  - Negate quotient/remainder per flags.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
- Final sign fix-up and selection happen on the RUN to DONE transition; result is registered.
- flush:
  - Forces IDLE next cycle from any state.
  - Suppresses done.
  - Leaves result and rd_out unchanged.
  - flush with start in the same cycle: flush wins, no accept.
- start with flush=0 during RUN: ignored (the pipeline is stalled, so the instruction is unchanged).
- All arithmetic is modulo 2^32 on outputs. Inputs are sampled only at accept, so changes during RUN have no effect.

Decomposition:
- Shared package muldiv_pkg:
  - muldiv_op_e enum (funct3 encodings).
  - muldiv_state_e (IDLE, RUN, DONE).
  - Constants DIV0_QUOTIENT=32'hFFFFFFFF and INT_MIN=32'h80000000.
  - Helper function is_signed_a/is_signed_b(op).
- One natural sub-module: muldiv_sign_fixup. It is combinational: 64-bit conditional negate plus result select by op. It is reused on the DONE edge.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> stall high cycles 0..32; done in cycle 33, result 0xFFFFFFEB, rd_out = latched rd_in.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-20, b=3 -> result 0xFFFFFFFA (-6). REM same -> 0xFFFFFFFE (-2). DIVU a=100, b=7 -> 14. REMU -> 2.
- Fast paths, each with done in cycle 1 and stall low in cycle 0:
  - DIV a=5, b=0 -> 0xFFFFFFFF.
  - REMU a=5, b=0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Abort cases:
  - flush asserted in cycle 10 of a DIV -> no done pulse, busy low in cycle 11, result keeps its previous value.
  - start with flush in the same cycle -> not accepted.
  - rst at cycle 20 -> all outputs 0 next cycle.
- Back-to-back: start held high through DONE with a new MUL 3*4 -> second accept in cycle 33, done again in cycle 66 with result 12; start pulses during RUN are ignored.
